// File: rtl/sa_input_skewer.sv
`default_nettype none
// ============================================================================
// Module   : sa_input_skewer
// Purpose  : Diagonal input skew feeder for the systolic array (row r delayed
//            r cycles). Optional bubble counter: SA_SKEW_BUBBLE_CNT_EN.
// Revision : 1.0
// ============================================================================
module sa_input_skewer #(
    parameter int SA_SIZE         = 8,
    parameter int ACTIVATION_SIZE = 8
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [SA_SIZE*ACTIVATION_SIZE-1:0]   in_data,
    input  logic                                 in_last,
    output logic [SA_SIZE*ACTIVATION_SIZE-1:0]   sa_inputs,
    output logic                                 busy,
`ifdef SA_SKEW_BUBBLE_CNT_EN
    output logic [15:0]                          bubble_cnt,
`endif
    output logic                                 tile_done
);

    localparam int CNT_W = $clog2(SA_SIZE);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(SA_SIZE - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] drain_cnt;
    logic             tile_end;
    logic             accept;

    assign in_ready = resetn && (state != DRAIN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        tile_end   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = in_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (accept && in_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    next_state = IDLE;
                    tile_end   = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Loaded on DRAIN entry so the exit edge lines up with the last beat
    // reaching the final stage of the longest row.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            drain_cnt <= '0;
        end else if ((state != DRAIN) && (next_state == DRAIN)) begin
            drain_cnt <= DRAIN_LOAD;
        end else if ((state == DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tile_done <= 1'b0;
        end else begin
            tile_done <= tile_end;
        end
    end

    for (genvar r = 0; r < SA_SIZE; r++) begin : g_row
        logic [ACTIVATION_SIZE-1:0] stg [0:r];

        always_ff @(posedge clk) begin
            if (!resetn) begin
                for (int s = 0; s <= r; s++) begin
                    stg[s] <= '0;
                end
            end else begin
                stg[0] <= accept ? in_data[r*ACTIVATION_SIZE +: ACTIVATION_SIZE]
                                 : '0;
                for (int s = 1; s <= r; s++) begin
                    stg[s] <= stg[s-1];
                end
            end
        end

        assign sa_inputs[r*ACTIVATION_SIZE +: ACTIVATION_SIZE] = stg[r];
    end

`ifdef SA_SKEW_BUBBLE_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bubble_cnt <= 16'h0000;
        end else if ((state == IDLE) && accept) begin
            bubble_cnt <= 16'h0000;
        end else if ((state == STREAM) && !accept && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'h0001;
        end
    end
`endif

endmodule
`default_nettype wire
